uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a show-ahead byte queue, with frame and overrun error pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits and the parity_err pulse.
`timescale 1ns/1ps
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_empty,
  output logic                 rx_full,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t               state_q, state_d;
  logic                 rx_s1_q, rx_s2_q, rx_prev_q;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tick, os_last, start_edge;
  logic                 push_req, frame_err_d, parity_err_d, overrun_d;
  logic                 frame_err_q, overrun_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q;
`endif

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 pop, do_push;

  // Synchronizer; rx_prev_q gives the previous synchronized level for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // A low line after a bad stop bit never produces an edge, so IDLE waits for high
  assign start_edge = rx_prev_q & ~rx_s2_q;
  assign tick       = (div_cnt_q == DIV_W'(DIV - 1));
  assign os_last    = (os_cnt_q == OS_W'(OVERSAMPLE - 1));

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
    os_cnt_d     = os_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    push_req     = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d   = S_START;
          div_cnt_d = '0;
          os_cnt_d  = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
            os_cnt_d  = '0;
            bit_cnt_d = '0;
            state_d   = rx_s2_q ? S_IDLE : S_DATA;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (os_last) begin
            os_cnt_d  = '0;
            shreg_d   = {rx_s2_q, shreg_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (os_last) begin
            os_cnt_d  = '0;
            par_bad_d = rx_s2_q ^ (^shreg_q);
            state_d   = S_STOP;
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (os_last) begin
            os_cnt_d = '0;
            state_d  = S_IDLE;
            if (!rx_s2_q) begin
              frame_err_d = 1'b1;
            end else begin
              push_req = 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_d = par_bad_q;
`endif
            end
          end else begin
            os_cnt_d = os_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Receiver state and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= '0;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      os_cnt_q  <= os_cnt_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  // Queue: a pop frees the slot a simultaneous push into a full queue needs
  assign rx_empty  = (count_q == '0);
  assign rx_full   = (count_q == CNT_W'(FIFO_DEPTH));
  assign pop       = rd_en & ~rx_empty;
  assign do_push   = push_req & (~rx_full | pop);
  assign overrun_d = push_req & rx_full & ~pop;

  always_comb begin
    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q      <= count_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign rx_data   = rx_empty ? '0 : mem_q[rd_ptr_q];
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0 & parity_err_d;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at a scaled clock/baud (4 clocks per tick, 64 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 640_000;
  localparam int BAUD     = 10_000;
  localparam int OS       = 16;
  localparam int DIVV     = CLK_FREQ / (BAUD * OS);
  localparam int BITC     = DIVV * OS;
`ifdef UART_RX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS    = 10 + PAR;
  // start drive -> 3 cycles to reach START, then stop sample at tick OS/2 + (9+PAR)*OS
  localparam int PUSH_CYC = 3 + DIVV * (OS / 2 + OS * (9 + PAR));

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_empty, rx_full, frame_err, overrun, parity_err;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
  int fall_cyc = -1;
  logic prev_empty = 1'b1;

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .rd_en(rd_en), .rx_data(rx_data),
    .rx_empty(rx_empty), .rx_full(rx_full), .frame_err(frame_err),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err)  fe_cnt++;
    if (overrun)    ov_cnt++;
    if (parity_err) pe_cnt++;
    if (prev_empty && !rx_empty) fall_cyc = cyc;
    prev_empty = rx_empty;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1);
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_v);
    logic [10:0] f;
    f = (PAR == 1) ? {stop_v, par_v, d, 1'b0} : {1'b1, stop_v, d, 1'b0};
    for (int i = 0; i < NBITS; i++) begin
      rx = f[i];
      wait_cycles(BITC);
    end
    rx = 1'b1;
  endtask

  task automatic send_ok(input logic [7:0] d);
    send_frame(d, 1'b1, even_par(d));
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_cycles(4);
    checks++; if (rx_empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", rx_empty); else passed++;
    checks++; if (rx_full !== 1'b0) $display("FAIL reset_full: got %b expected 0", rx_full); else passed++;
    checks++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", rx_data); else passed++;
    checks++;
    if ({frame_err, overrun, parity_err} !== 3'b000)
      $display("FAIL reset_pulses: got %b expected 000", {frame_err, overrun, parity_err});
    else passed++;
    rst = 1'b0;
    wait_cycles(4);
  endtask

  task automatic test_single_byte();
    int c0, fe0, ov0, pe0;
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt;
    fall_cyc = -1;
    c0 = cyc;
    send_ok(8'h35);
    wait_cycles(8);
    checks++; if (rx_empty !== 1'b0) $display("FAIL single_empty: got %b expected 0", rx_empty); else passed++;
    checks++; if (rx_data !== 8'h35) $display("FAIL single_data: got %h expected 35", rx_data); else passed++;
    checks++;
    if (fall_cyc - c0 !== PUSH_CYC) $display("FAIL single_latency: got %0d expected %0d", fall_cyc - c0, PUSH_CYC);
    else passed++;
    checks++;
    if ((fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0) !== 0)
      $display("FAIL single_errors: got %0d pulses expected 0", (fe_cnt - fe0) + (ov_cnt - ov0) + (pe_cnt - pe0));
    else passed++;
    pop_one();
    checks++; if (rx_empty !== 1'b1) $display("FAIL single_pop_empty: got %b expected 1", rx_empty); else passed++;
    checks++; if (rx_data !== 8'h00) $display("FAIL single_pop_data: got %h expected 00", rx_data); else passed++;
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    rx = 1'b0;
    wait_cycles(20);
    rx = 1'b1;
    wait_cycles(12 * BITC);
    checks++; if (rx_empty !== 1'b1) $display("FAIL glitch_empty: got %b expected 1", rx_empty); else passed++;
    checks++; if (fe_cnt !== fe0) $display("FAIL glitch_frame_err: got %0d expected %0d", fe_cnt, fe0); else passed++;
  endtask

  task automatic test_frame_err();
    int fe0;
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, even_par(8'hA5));
    wait_cycles(BITC);
    checks++; if (fe_cnt !== fe0 + 1) $display("FAIL ferr_pulse: got %0d expected %0d", fe_cnt - fe0, 1); else passed++;
    checks++; if (rx_empty !== 1'b1) $display("FAIL ferr_queue: got %b expected 1", rx_empty); else passed++;
    send_ok(8'h5A);
    wait_cycles(8);
    checks++; if (rx_data !== 8'h5A) $display("FAIL ferr_next_data: got %h expected 5a", rx_data); else passed++;
    checks++; if (fe_cnt !== fe0 + 1) $display("FAIL ferr_next_clean: got %0d expected %0d", fe_cnt - fe0, 1); else passed++;
    pop_one();
  endtask

  task automatic test_overrun_wrap();
    int ov0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 8; i++) send_ok(8'(i));
    wait_cycles(8);
    checks++; if (rx_full !== 1'b1) $display("FAIL ovr_full: got %b expected 1", rx_full); else passed++;
    checks++; if (ov_cnt !== ov0) $display("FAIL ovr_none_yet: got %0d expected 0", ov_cnt - ov0); else passed++;
    send_ok(8'h09);
    wait_cycles(8);
    checks++; if (ov_cnt !== ov0 + 1) $display("FAIL ovr_pulse: got %0d expected 1", ov_cnt - ov0); else passed++;
    checks++; if (rx_data !== 8'h01) $display("FAIL ovr_head: got %h expected 01", rx_data); else passed++;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (rx_data !== 8'(i)) $display("FAIL ovr_pop%0d: got %h expected %h", i, rx_data, 8'(i));
      else passed++;
      pop_one();
    end
    checks++; if (rx_empty !== 1'b1) $display("FAIL ovr_drained: got %b expected 1", rx_empty); else passed++;
    send_ok(8'h0A);
    send_ok(8'h0B);
    wait_cycles(8);
    checks++; if (rx_data !== 8'h0A) $display("FAIL wrap_first: got %h expected 0a", rx_data); else passed++;
    pop_one();
    checks++; if (rx_data !== 8'h0B) $display("FAIL wrap_second: got %h expected 0b", rx_data); else passed++;
    pop_one();
  endtask

  task automatic test_simultaneous();
    int ov0;
    for (int i = 0; i < 8; i++) send_ok(8'h10 + 8'(i));
    wait_cycles(8);
    ov0 = ov_cnt;
    fork
      send_ok(8'h18);
      begin
        wait_cycles(PUSH_CYC - 1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    wait_cycles(4);
    checks++; if (ov_cnt !== ov0) $display("FAIL simul_overrun: got %0d expected 0", ov_cnt - ov0); else passed++;
    checks++; if (rx_full !== 1'b1) $display("FAIL simul_full: got %b expected 1", rx_full); else passed++;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_data !== 8'h11 + 8'(i)) $display("FAIL simul_pop%0d: got %h expected %h", i, rx_data, 8'h11 + 8'(i));
      else passed++;
      pop_one();
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    int fe0;
    send_ok(8'h77);
    wait_cycles(8);
    checks++; if (rx_empty !== 1'b0) $display("FAIL rstmid_preload: got %b expected 0", rx_empty); else passed++;
    d = 8'h35;
    rx = 1'b0;
    wait_cycles(BITC);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      wait_cycles(BITC);
    end
    rx = d[4];
    wait_cycles(BITC / 2);
    rst = 1'b1;
    wait_cycles(1);
    checks++; if (rx_empty !== 1'b1) $display("FAIL rstmid_empty: got %b expected 1", rx_empty); else passed++;
    checks++; if (rx_full !== 1'b0) $display("FAIL rstmid_full: got %b expected 0", rx_full); else passed++;
    checks++; if (rx_data !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", rx_data); else passed++;
    wait_cycles(1);
    rst = 1'b0;
    rx = 1'b1;
    wait_cycles(2 * BITC);
    fe0 = fe_cnt;
    send_ok(8'h35);
    wait_cycles(8);
    checks++; if (rx_data !== 8'h35) $display("FAIL rstmid_after: got %h expected 35", rx_data); else passed++;
    checks++; if (fe_cnt !== fe0) $display("FAIL rstmid_ferr: got %0d expected 0", fe_cnt - fe0); else passed++;
    pop_one();
  endtask

  task automatic test_parity();
    int pe0;
    pe0 = pe_cnt;
    send_frame(8'h35, 1'b1, 1'b1);
    wait_cycles(8);
    checks++; if (rx_data !== 8'h35) $display("FAIL parity_data: got %h expected 35", rx_data); else passed++;
    checks++;
    if (pe_cnt !== pe0 + PAR) $display("FAIL parity_pulse: got %0d expected %0d", pe_cnt - pe0, PAR);
    else passed++;
    pop_one();
    send_ok(8'h36);
    wait_cycles(8);
    checks++;
    if (pe_cnt !== pe0 + PAR) $display("FAIL parity_good: got %0d expected %0d", pe_cnt - pe0, PAR);
    else passed++;
    pop_one();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_err();
    test_overrun_wrap();
    test_simultaneous();
    test_reset_midframe();
    test_parity();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
